// File: rtl/modexp_arbiter.sv
// Round-robin arbiter sharing one modular-exponentiation engine among NUM_REQ requesters.
// Operands are latched at grant; results and timeouts are reported back as one-hot/1-cycle pulses.
module modexp_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic [NUM_REQ-1:0]     req_in,
  input  logic [8*NUM_REQ-1:0]   value_in,
  input  logic [8*NUM_REQ-1:0]   modulus_in,
  input  logic [8*NUM_REQ-1:0]   exponent_in,
  output logic [NUM_REQ-1:0]     ack_out,
  output logic [15:0]            result_out,
  output logic [NUM_REQ-1:0]     result_valid_out,
  output logic                   timeout_out,
  output logic                   busy_out,
  output logic                   engine_ready_out,
  output logic [7:0]             engine_value_out,
  output logic [7:0]             engine_modulus_out,
  output logic [7:0]             engine_exponent_out,
  input  logic                   engine_busy_in,
  input  logic                   engine_valid_in,
  input  logic [15:0]            engine_value_in
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   idx;
  logic [CNT_W-1:0]   cnt;
  logic [NUM_REQ-1:0] ack_q;
  logic               timeout_q;
  logic [15:0]        result_q;
  logic [7:0]         op_value;
  logic [7:0]         op_modulus;
  logic [7:0]         op_exponent;

  logic               sel_found;
  logic [IDX_W-1:0]   sel_idx;
  logic [7:0]         sel_value;
  logic [7:0]         sel_modulus;
  logic [7:0]         sel_exponent;

  logic               grant;
  logic               capture;
  logic               expire;
  logic               advance;

  // Scan requesters starting at the round-robin pointer, wrapping at NUM_REQ.
  always_comb begin
    int cand;
    cand      = 0;
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = (int'(ptr) + i) % NUM_REQ;
      if (!sel_found && req_in[cand]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(cand);
      end
    end
  end

  assign sel_value    = value_in[8*sel_idx +: 8];
  assign sel_modulus  = modulus_in[8*sel_idx +: 8];
  assign sel_exponent = exponent_in[8*sel_idx +: 8];

  always_comb begin
    state_next = state;
    grant      = 1'b0;
    capture    = 1'b0;
    expire     = 1'b0;
    case (state)
      S_IDLE: begin
        if (sel_found) begin
          grant      = 1'b1;
          state_next = (sel_modulus == 8'h00) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!engine_busy_in) state_next = S_WAIT;
      end
      S_WAIT: begin
        // A result arriving on the last allowed cycle still counts.
        if (engine_valid_in) begin
          capture    = 1'b1;
          state_next = S_DONE;
        end else if (cnt == CNT_LAST) begin
          expire     = 1'b1;
          state_next = S_IDLE;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign advance = (state == S_DONE) || expire;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      ptr         <= '0;
      idx         <= '0;
      cnt         <= '0;
      ack_q       <= '0;
      timeout_q   <= 1'b0;
      result_q    <= '0;
      op_value    <= '0;
      op_modulus  <= '0;
      op_exponent <= '0;
    end else begin
      ack_q     <= grant ? (NUM_REQ'(1) << sel_idx) : '0;
      timeout_q <= expire;

      if (grant) begin
        idx         <= sel_idx;
        op_value    <= sel_value;
        op_modulus  <= sel_modulus;
        op_exponent <= sel_exponent;
        if (sel_modulus == 8'h00) result_q <= '0;
      end

      if (capture) result_q <= engine_value_in;

      if (state == S_WAIT && !capture && !expire) begin
        cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
      end

      if (advance) ptr <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end
  end

  assign ack_out             = ack_q;
  assign timeout_out         = timeout_q;
  assign result_out          = result_q;
  assign busy_out            = (state != S_IDLE);
  assign engine_ready_out    = (state == S_ISSUE) && !engine_busy_in;
  assign result_valid_out    = (state == S_DONE) ? (NUM_REQ'(1) << idx) : '0;
  assign engine_value_out    = op_value;
  assign engine_modulus_out  = op_modulus;
  assign engine_exponent_out = op_exponent;

endmodule

// File: tb/tb_modexp_arbiter.sv
// Directed bench for modexp_arbiter: a vector table of whole transactions plus
// hand-written sequences for round-robin, timeout and mid-transaction reset.
module tb_modexp_arbiter;

  logic        clk_in;
  logic        rst_in;
  logic [3:0]  req_in;
  logic [31:0] value_in;
  logic [31:0] modulus_in;
  logic [31:0] exponent_in;
  logic [3:0]  ack_out;
  logic [15:0] result_out;
  logic [3:0]  result_valid_out;
  logic        timeout_out;
  logic        busy_out;
  logic        engine_ready_out;
  logic [7:0]  engine_value_out;
  logic [7:0]  engine_modulus_out;
  logic [7:0]  engine_exponent_out;
  logic        engine_busy_in;
  logic        engine_valid_in;
  logic [15:0] engine_value_in;

  int n_checks = 0;
  int n_fail   = 0;
  bit fire_valid;

  modexp_arbiter #(.NUM_REQ(4), .TIMEOUT(16)) dut (
    .clk_in              (clk_in),
    .rst_in              (rst_in),
    .req_in              (req_in),
    .value_in            (value_in),
    .modulus_in          (modulus_in),
    .exponent_in         (exponent_in),
    .ack_out             (ack_out),
    .result_out          (result_out),
    .result_valid_out    (result_valid_out),
    .timeout_out         (timeout_out),
    .busy_out            (busy_out),
    .engine_ready_out    (engine_ready_out),
    .engine_value_out    (engine_value_out),
    .engine_modulus_out  (engine_modulus_out),
    .engine_exponent_out (engine_exponent_out),
    .engine_busy_in      (engine_busy_in),
    .engine_valid_in     (engine_valid_in),
    .engine_value_in     (engine_value_in)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] value;
    logic [31:0] modulus;
    logic [31:0] exponent;
    int          busy;
    logic [15:0] eng;
    logic [3:0]  exp_ack;
    int          exp_ready;
    logic [3:0]  exp_rv;
    logic [15:0] exp_result;
    logic [23:0] exp_ops;
  } vec_t;

  vec_t vecs[8];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // One full transaction: the engine answers the cycle after engine_ready_out,
  // inputs are scrambled after the grant to prove operands were latched.
  task automatic applyStimulus(input vec_t v, input int n);
    logic [3:0]  ack_seen, rv_seen;
    logic [23:0] ops;
    int          ready_cnt, ready_busy, ack_cyc, busy_left, to_seen;
    bit          fire, done;
    ack_seen = '0; rv_seen = '0; ops = '0;
    ready_cnt = 0; ready_busy = 0; ack_cyc = -1; to_seen = 0;
    fire = 1'b0; done = 1'b0;
    @(posedge clk_in); #1;
    req_in = v.req; value_in = v.value; modulus_in = v.modulus; exponent_in = v.exponent;
    busy_left = v.busy;
    engine_busy_in = (busy_left > 0);
    engine_valid_in = 1'b0;
    for (int c = 0; c < 64 && !done; c++) begin
      @(posedge clk_in); #1;
      engine_valid_in = fire;
      engine_value_in = fire ? v.eng : 16'h0000;
      fire = 1'b0;
      if (busy_left > 0) busy_left--;
      engine_busy_in = (busy_left > 0);
      #1;
      if (ack_out != 4'b0000) begin
        ack_seen |= ack_out;
        ack_cyc = c;
        req_in = 4'b0000;
        value_in = ~v.value; modulus_in = ~v.modulus; exponent_in = ~v.exponent;
      end
      if (engine_ready_out) begin
        ready_cnt++;
        fire = 1'b1;
        if (engine_busy_in) ready_busy++;
      end
      if (timeout_out) to_seen++;
      rv_seen |= result_valid_out;
      if (busy_out) ops = {engine_value_out, engine_modulus_out, engine_exponent_out};
      else done = 1'b1;
    end
    engine_valid_in = 1'b0;
    checkOutput($sformatf("v%0d_done", n), 32'(done), 32'd1);
    checkOutput($sformatf("v%0d_ack", n), 32'(ack_seen), 32'(v.exp_ack));
    checkOutput($sformatf("v%0d_ack_latency", n), 32'(ack_cyc), 32'd0);
    checkOutput($sformatf("v%0d_ready_count", n), 32'(ready_cnt), 32'(v.exp_ready));
    checkOutput($sformatf("v%0d_ready_while_busy", n), 32'(ready_busy), 32'd0);
    checkOutput($sformatf("v%0d_result_valid", n), 32'(rv_seen), 32'(v.exp_rv));
    checkOutput($sformatf("v%0d_result", n), 32'(result_out), 32'(v.exp_result));
    checkOutput($sformatf("v%0d_operands", n), 32'(ops), 32'(v.exp_ops));
    checkOutput($sformatf("v%0d_no_timeout", n), 32'(to_seen), 32'd0);
  endtask

  task automatic drainTxn(input string name);
    for (int c = 0; c < 40; c++) begin
      if (!busy_out) break;
      @(posedge clk_in); #1;
      engine_valid_in = fire_valid;
      engine_value_in = 16'h0042;
      fire_valid = 1'b0;
      #1;
      if (engine_ready_out) fire_valid = 1'b1;
    end
    engine_valid_in = 1'b0;
    checkOutput(name, 32'(busy_out), 32'd0);
  endtask

  logic [3:0] exp_rr[5];
  vec_t       v_ptr;
  int         g, last_c, rdy_c, to_c, to_cnt;
  logic [3:0] rv_acc;
  logic       to_busy, busy_acc, to_acc;

  initial begin
    // Pointer walk: 0 ->1 ->1 ->0 ->1 ->3 ->2 ->3 ->1
    vecs[0] = '{4'b0001, 32'h0A0B0C03, 32'h1D1E1F07, 32'h2A2B2C04, 0, 16'd4,
                4'b0001, 1, 4'b0001, 16'd4,      {8'h03, 8'h07, 8'h04}};
    vecs[1] = '{4'b0001, 32'h0A0B0C05, 32'h1D1E1F0D, 32'h2A2B2C02, 0, 16'd12,
                4'b0001, 1, 4'b0001, 16'd12,     {8'h05, 8'h0D, 8'h02}};
    vecs[2] = '{4'b1001, 32'h090B0C05, 32'h0B1E1F0D, 32'h032B2C02, 0, 16'd3,
                4'b1000, 1, 4'b1000, 16'd3,      {8'h09, 8'h0B, 8'h03}};
    vecs[3] = '{4'b1001, 32'h090B0C05, 32'h0B1E1F0D, 32'h032B2C02, 0, 16'd12,
                4'b0001, 1, 4'b0001, 16'd12,     {8'h05, 8'h0D, 8'h02}};
    vecs[4] = '{4'b0100, 32'h0A060C05, 32'h1D001F0D, 32'h2A052C02, 0, 16'hBEEF,
                4'b0100, 0, 4'b0100, 16'h0000,   {8'h06, 8'h00, 8'h05}};
    vecs[5] = '{4'b0110, 32'h0A060205, 32'h1D000F0D, 32'h2A050A02, 5, 16'd4,
                4'b0010, 1, 4'b0010, 16'd4,      {8'h02, 8'h0F, 8'h0A}};
    vecs[6] = '{4'b0110, 32'h0A060205, 32'h1D000F0D, 32'h2A050A02, 0, 16'h1111,
                4'b0100, 0, 4'b0100, 16'h0000,   {8'h06, 8'h00, 8'h05}};
    vecs[7] = '{4'b0001, 32'h0A0B0C03, 32'h1D1E1F07, 32'h2A2B2C04, 0, 16'hA5C3,
                4'b0001, 1, 4'b0001, 16'hA5C3,   {8'h03, 8'h07, 8'h04}};
    exp_rr = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    rst_in = 1'b1; req_in = '0; value_in = '0; modulus_in = '0; exponent_in = '0;
    engine_busy_in = 1'b0; engine_valid_in = 1'b0; engine_value_in = '0; fire_valid = 1'b0;
    repeat (2) @(posedge clk_in);
    #1 rst_in = 1'b0;

    for (int i = 0; i < 8; i++) applyStimulus(vecs[i], i);

    // Reset after activity must clear result, operands and pointer.
    @(posedge clk_in); #1 rst_in = 1'b1;
    @(posedge clk_in); #1;
    checkOutput("rst_result", 32'(result_out), 32'd0);
    checkOutput("rst_pulses", 32'({ack_out, result_valid_out, timeout_out, engine_ready_out, busy_out}), 32'd0);
    checkOutput("rst_operands", 32'({engine_value_out, engine_modulus_out, engine_exponent_out}), 32'd0);
    rst_in = 1'b0;

    // All requesters held: grants rotate 0,1,2,3,0 every 4 cycles.
    @(posedge clk_in); #1;
    req_in = 4'b1111; value_in = 32'h04030201; modulus_in = 32'h07070707; exponent_in = 32'h02020202;
    g = 0; last_c = 0; fire_valid = 1'b0;
    for (int c = 0; c < 100 && g < 5; c++) begin
      @(posedge clk_in); #1;
      engine_valid_in = fire_valid; engine_value_in = 16'h0042; fire_valid = 1'b0;
      #1;
      if (engine_ready_out) fire_valid = 1'b1;
      if (ack_out != 4'b0000) begin
        checkOutput($sformatf("rr_grant%0d", g), 32'(ack_out), 32'(exp_rr[g]));
        if (g > 0) checkOutput($sformatf("rr_period%0d", g), 32'(c - last_c), 32'd4);
        last_c = c;
        g++;
        if (g == 5) req_in = 4'b0000;
      end
    end
    checkOutput("rr_grant_count", 32'(g), 32'd5);
    drainTxn("rr_drain_idle");

    // Engine never answers: timeout 16 cycles after entering WAIT, pointer 1 -> 2.
    @(posedge clk_in); #1;
    req_in = 4'b0010; value_in = 32'h01020304; modulus_in = 32'h0B0B0B0B; exponent_in = 32'h05050505;
    rdy_c = -100; to_c = -100; to_cnt = 0; rv_acc = '0; to_busy = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk_in); #1; engine_valid_in = 1'b0; #1;
      if (ack_out != 4'b0000) req_in = 4'b0000;
      if (engine_ready_out) rdy_c = c;
      if (timeout_out) begin to_cnt++; to_c = c; to_busy = busy_out; end
      rv_acc |= result_valid_out;
    end
    checkOutput("to_pulse_count", 32'(to_cnt), 32'd1);
    checkOutput("to_delay", 32'(to_c - rdy_c), 32'd17);
    checkOutput("to_no_result_valid", 32'(rv_acc), 32'd0);
    checkOutput("to_busy_low", 32'(to_busy), 32'd0);

    v_ptr = '{4'b0110, 32'h01020304, 32'h0B0B0B0B, 32'h05050505, 0, 16'h0077,
              4'b0100, 1, 4'b0100, 16'h0077, {8'h02, 8'h0B, 8'h05}};
    applyStimulus(v_ptr, 8);

    // Reset while in WAIT, then a stray engine result.
    @(posedge clk_in); #1;
    req_in = 4'b0001; value_in = 32'h01020304; modulus_in = 32'h0B0B0B0B; exponent_in = 32'h05050505;
    @(posedge clk_in); #2;
    checkOutput("rstw_ack", 32'(ack_out), 32'b0001);
    checkOutput("rstw_ready", 32'(engine_ready_out), 32'd1);
    req_in = 4'b0000;
    @(posedge clk_in); #1 rst_in = 1'b1; #1;
    checkOutput("rstw_in_wait", 32'(busy_out), 32'd1);
    @(posedge clk_in); #1;
    rst_in = 1'b0; engine_valid_in = 1'b1; engine_value_in = 16'h5555;
    rv_acc = '0; to_acc = 1'b0; busy_acc = 1'b0;
    for (int c = 0; c < 6; c++) begin
      #1;
      rv_acc |= result_valid_out; to_acc |= timeout_out; busy_acc |= busy_out;
      @(posedge clk_in); #1; engine_valid_in = 1'b0;
    end
    checkOutput("rstw_busy", 32'(busy_acc), 32'd0);
    checkOutput("rstw_no_result_valid", 32'(rv_acc), 32'd0);
    checkOutput("rstw_no_timeout", 32'(to_acc), 32'd0);
    checkOutput("rstw_result", 32'(result_out), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
